uart_fifo_tx: RTL
=================

Name: uart_fifo_tx

Overview:
UART transmitter that drains the sender-side FIFO and serializes each word onto the serial line.
- Reads a first-word-fall-through FIFO: data is valid whenever empty is low, and a one-cycle rd pulse pops it.
- Frame: 1 start bit (0), DBIT data bits LSB first, optional parity bit, stop period (1).
- Contains its own 16x oversampling baud-tick generator, so it needs only the system clock.

Parameters:
DBIT, 8, data bits per frame; must equal the FIFO word width B.
SB_TICK, 16, stop period length in oversample ticks (16 = 1 stop bit, 24 = 1.5, 32 = 2).
DVSR, 27, clk cycles per oversample tick (50 MHz / (16 x 115200)); must be >= 1.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  synchronous, active-high.
fifo_empty  in  1  FIFO empty flag.
fifo_data  in  DBIT  FIFO head word; valid while fifo_empty = 0.
fifo_rd  out  1  one-cycle pop strobe to the FIFO.
tx  out  1  serial line; idle high.
tx_busy  out  1  high while a frame is in progress.
tx_done_tick  out  1  one-cycle pulse at the end of each frame.

Behaviour:
- Interface (decided): one clock, clk; reset is synchronous and active-high; all state updates on the rising edge of clk.
- Reset values:
  - outputs: tx = 1, fifo_rd = 0, tx_busy = 0, tx_done_tick = 0.
  - internal: state = IDLE, all counters = 0, shift register = 0.
- Baud generator:
  - counter runs 0..DVSR-1; tick is asserted in the cycle where count = DVSR-1.
  - counter is forced to 0 in IDLE, so every frame starts phase-aligned.
  - result: every data/start/parity bit lasts exactly 16 x DVSR clk cycles; the stop period lasts SB_TICK x DVSR cycles.
- FSM states: IDLE, START, DATA, PARITY (only when the optional feature is compiled in), STOP.
- IDLE:
  - tx = 1.
  - If fifo_empty = 0: load fifo_data into the shift register, assert fifo_rd for that single cycle, and go to START.
  - Otherwise stay in IDLE.
- START:
  - tx = 0.
  - Count 16 ticks (tick counter s: 0..15).
  - On the 16th tick: s <= 0, bit counter n <= 0, go to DATA.
- DATA:
  - tx = shift register bit 0.
  - After 16 ticks: shift right by one, s <= 0, n <= n+1.
  - When n = DBIT-1 at that point, go to PARITY or STOP.
  - Bit counter width is clog2(DBIT).
- STOP:
  - tx = 1.
  - After SB_TICK ticks: assert tx_done_tick for one cycle (the transition cycle) and go to IDLE.
- tx_busy = 1 in every state except IDLE.
- Latency:
  - tx falls on the clk edge after the cycle in which fifo_rd is high (tx is registered).
  - Back-to-back frames: IDLE lasts exactly 1 cycle between STOP and the next START when the FIFO is non-empty, so the inter-frame gap is SB_TICK x DVSR + 1 cycles of line-high.
- Boundary conditions:
  - fifo_rd is never asserted while fifo_empty = 1 or outside IDLE.
  - At most one pop per frame.
  - FIFO going empty mid-frame has no effect; the block returns to IDLE after STOP and waits.
  - fifo_data changes during a frame are ignored because the word is latched at pop time.
  - Reset mid-frame: on the next edge tx = 1, the frame is aborted, and the popped word is discarded (not re-read). No tx_done_tick is produced.
- tx is driven from a register; it must have no combinational path from any input.

Optional Feature:
UART_TX_PARITY_EN.
- Defined:
  - A PARITY state follows DATA.
  - tx = XOR of the DBIT data bits (even parity), held for 16 ticks.
  - Parity is computed at load time and stored in its own register.
  - Frame length = (1 + DBIT + 1) x 16 x DVSR + SB_TICK x DVSR cycles.
- Undefined:
  - PARITY state and parity register are absent; DATA goes directly to STOP.

Test Plan:
- Reset with fifo_empty = 1 held for 100 cycles -> tx = 1, tx_busy = 0, fifo_rd never asserted.
- DVSR = 2, SB_TICK = 16, FIFO holds 0xA5 ->
  - fifo_rd high for exactly 1 cycle;
  - tx: 0 for 32 cycles, then bits 1,0,1,0,0,1,0,1 at 32 cycles each, then 1 for 32 cycles;
  - one tx_done_tick at frame end; total frame = 320 cycles.
- FIFO pre-loaded with 0x00, 0xFF, 0x3C (DVSR = 2) -> three frames decoded correctly by a bench UART receiver, exactly 3 fifo_rd pulses, exactly 1 idle cycle between frames.
- Assert reset for 1 cycle during the DATA bit 3 of 0x55 -> tx = 1 on the next edge, state IDLE, no tx_done_tick; the following word 0x81 is transmitted intact.
- fifo_data toggled randomly during a frame of 0x96 -> received byte = 0x96.
- UART_TX_PARITY_EN defined, send 0x07 then 0x03 -> parity bit 1 then 0; frame = 352 cycles at DVSR = 2.

Source files
------------

// File: rtl/uart_fifo_tx.sv
// -----------------------------------------------------------------------------
// uart_fifo_tx
//
// UART transmitter that drains a first-word-fall-through FIFO and serializes
// each word as: start bit (0), DBIT data bits LSB first, optional even parity
// bit, stop period (1). A private baud-tick generator produces one oversample
// tick every DVSR clk cycles; each start/data/parity bit lasts 16 ticks and
// the stop period lasts SB_TICK ticks.
//
// Optional feature macro: UART_TX_PARITY_EN
//   defined   -> a PARITY state follows DATA and carries the XOR of the data
//                bits (even parity), computed when the word is popped.
//   undefined -> no PARITY state and no parity register; DATA goes to STOP.
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   synchronous, active-high reset
//   fifo_empty   in   FIFO empty flag
//   fifo_data    in   FIFO head word (valid while fifo_empty = 0)
//   fifo_rd      out  one-cycle pop strobe, only asserted in IDLE
//   tx           out  serial line, registered, idle high
//   tx_busy      out  high while a frame is in progress
//   tx_done_tick out  one-cycle pulse in the last cycle of the stop period
// -----------------------------------------------------------------------------
module uart_fifo_tx #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int DVSR    = 27
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            fifo_empty,
    input  logic [DBIT-1:0] fifo_data,
    output logic            fifo_rd,
    output logic            tx,
    output logic            tx_busy,
    output logic            tx_done_tick
);

    localparam int C_W = (DVSR > 1) ? $clog2(DVSR) : 1;
    localparam int N_W = (DBIT > 1) ? $clog2(DBIT) : 1;
    localparam int S_W = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;

    localparam logic [C_W-1:0] C_LAST    = C_W'(DVSR - 1);
    localparam logic [N_W-1:0] N_LAST    = N_W'(DBIT - 1);
    localparam logic [S_W-1:0] S_BIT_END = S_W'(15);
    localparam logic [S_W-1:0] S_STOP_END = S_W'(SB_TICK - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t          state, state_next;
    logic [C_W-1:0]  baud_cnt, baud_next;
    logic [S_W-1:0]  s, s_next;
    logic [N_W-1:0]  n, n_next;
    logic [DBIT-1:0] b, b_next;
    logic            tx_reg, tx_next;
    logic            tick;
    logic            rd_c;
    logic            done_c;
`ifdef UART_TX_PARITY_EN
    logic            par, par_next;
`endif

    // NOTE: sequential state is updated only with non-blocking assignments so
    // every register samples the values from before the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            s        <= '0;
            n        <= '0;
            b        <= '0;
            tx_reg   <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par      <= 1'b0;
`endif
        end else begin
            state    <= state_next;
            baud_cnt <= baud_next;
            s        <= s_next;
            n        <= n_next;
            b        <= b_next;
            tx_reg   <= tx_next;
`ifdef UART_TX_PARITY_EN
            par      <= par_next;
`endif
        end
    end

    // Baud counter is held at zero in IDLE so every frame starts phase-aligned.
    always_comb begin
        tick = (state != IDLE) && (baud_cnt == C_LAST);
        if (state == IDLE || tick) baud_next = '0;
        else                       baud_next = baud_cnt + C_W'(1);
    end

    // NOTE: every variable driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_next = state;
        s_next     = s;
        n_next     = n;
        b_next     = b;
        rd_c       = 1'b0;
        done_c     = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_next   = par;
`endif
        case (state)
            IDLE: begin
                // The pop is suppressed during reset so a word is never
                // consumed by a frame that the reset is about to discard.
                if (!fifo_empty && !reset) begin
                    rd_c       = 1'b1;
                    b_next     = fifo_data;
                    s_next     = '0;
                    state_next = START;
`ifdef UART_TX_PARITY_EN
                    par_next   = ^fifo_data;
`endif
                end
            end
            START: begin
                if (tick) begin
                    if (s == S_BIT_END) begin
                        s_next     = '0;
                        n_next     = '0;
                        state_next = DATA;
                    end else begin
                        s_next = s + S_W'(1);
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (s == S_BIT_END) begin
                        s_next = '0;
                        b_next = b >> 1;
                        n_next = n + N_W'(1);
                        if (n == N_LAST) begin
`ifdef UART_TX_PARITY_EN
                            state_next = PARITY;
`else
                            state_next = STOP;
`endif
                        end
                    end else begin
                        s_next = s + S_W'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    if (s == S_BIT_END) begin
                        s_next     = '0;
                        state_next = STOP;
                    end else begin
                        s_next = s + S_W'(1);
                    end
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    if (s == S_STOP_END) begin
                        s_next     = '0;
                        done_c     = 1'b1;
                        state_next = IDLE;
                    end else begin
                        s_next = s + S_W'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        // The line level is decided from the state being entered, so tx
        // changes on the same edge as the state and stays a pure register.
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = b_next[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_next = par_next;
`endif
            default: tx_next = 1'b1;
        endcase
    end

    assign fifo_rd      = rd_c;
    assign tx           = tx_reg;
    assign tx_busy      = (state != IDLE);
    assign tx_done_tick = done_c;

endmodule
